step_clock_gen: RTL and testbench

Clock-source front end for the multi-cycle CPU. It produces the two candidate CPU clock sources that the manual/auto clock select stage chooses between:
- a debounced, fixed-width single-step pulse generated from a raw pushbutton;
- a free-running divided clock for automatic execution.

It also counts accepted step presses for the display logic.

---
 rtl/step_clock_gen.sv | 132 +++++++++++++
 tb/tb_step_clock_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - debounced single-step pulse, divided run clock and press counter
// Optional macro STEP_COUNT_EN builds the step_count register; otherwise step_count reads 0.
module step_clock_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DIV_HALF        = 4,
   parameter int STEP_HIGH       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic       div_en,
   output logic       step_out,
   output logic       div_clk,
   output logic       div_rise,
   output logic [7:0] step_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(STEP_HIGH + 1);
   localparam int VW = $clog2(DIV_HALF + 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] S_LAST = SW'(STEP_HIGH - 1);
   localparam logic [VW-1:0] V_LAST = VW'(DIV_HALF - 1);

   typedef enum logic [1:0] {IDLE, HIGH, WAIT_REL} state_t;

   state_t        state, state_next;
   logic          sync1, sync2;
   logic          btn_stable, btn_stable_q;
   logic [DW-1:0] dcnt;
   logic [SW-1:0] scnt, scnt_next;
   logic [VW-1:0] dv;
   logic          press;

   // Any return to the stable level restarts the debounce count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         btn_stable   <= 1'b0;
         btn_stable_q <= 1'b0;
         dcnt         <= '0;
      end else begin
         sync1        <= btn_raw;
         sync2        <= sync1;
         btn_stable_q <= btn_stable;
         if (sync2 == btn_stable) begin
            dcnt <= '0;
         end else if (dcnt == D_LAST) begin
            btn_stable <= sync2;
            dcnt       <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   assign press = btn_stable & ~btn_stable_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         scnt     <= '0;
         step_out <= 1'b0;
      end else begin
         state    <= state_next;
         scnt     <= scnt_next;
         step_out <= (state_next == HIGH);
      end
   end

   always_comb begin
      state_next = state;
      scnt_next  = scnt;
      case (state)
         IDLE: begin
            if (press) begin
               state_next = HIGH;
               scnt_next  = '0;
            end
         end
         HIGH: begin
            scnt_next = scnt + 1'b1;
            if (scnt == S_LAST) state_next = WAIT_REL;
         end
         WAIT_REL: begin
            if (!btn_stable) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef STEP_COUNT_EN
   logic [7:0] count_q;
   logic       accepted;

   assign accepted = (state == IDLE) && press;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else if (accepted) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign step_count = count_q;
`else
   assign step_count = 8'd0;
`endif

   // div_rise is registered alongside div_clk so it marks the first high cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dv       <= '0;
         div_clk  <= 1'b0;
         div_rise <= 1'b0;
      end else if (div_en) begin
         if (dv == V_LAST) begin
            dv       <= '0;
            div_clk  <= ~div_clk;
            div_rise <= ~div_clk;
         end else begin
            dv       <= dv + 1'b1;
            div_rise <= 1'b0;
         end
      end else begin
         div_rise <= 1'b0;
      end
   end

endmodule

// File: tb/tb_step_clock_gen.sv
// tb/tb_step_clock_gen.sv - scoreboard bench for step_clock_gen
module tb_step_clock_gen;

   localparam int DEB   = 16;
   localparam int DH    = 4;
   localparam int SH    = 8;
   localparam int LAT   = DEB + 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_raw;
   logic       div_en;
   logic       step_out;
   logic       div_clk;
   logic       div_rise;
   logic [7:0] step_count;

   step_clock_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .div_en     (div_en),
      .step_out   (step_out),
      .div_clk    (div_clk),
      .div_rise   (div_rise),
      .step_count (step_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int rise;
      int width;
      int cnt;
   } pulse_t;

   pulse_t sb[$];
   int     tests  = 0;
   int     fails  = 0;
   int     cyc    = 0;
   int     exp_cnt = 0;
   int     en_edges = 0;
   logic   last_en = 1'b0;

   task automatic check(input string tag, input int got, input int want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic int cnt_exp(input int n);
`ifdef STEP_COUNT_EN
      return n & 255;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         en_edges <= 0;
         last_en  <= 1'b0;
      end else if (div_en) begin
         en_edges <= en_edges + 1;
         last_en  <= 1'b1;
      end else begin
         last_en  <= 1'b0;
      end
   end

   // Divider reference: phase is set purely by the number of enabled edges since reset.
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("div_clk", int'(div_clk), (en_edges / DH) % 2);
         check("div_rise", int'(div_rise),
               int'(last_en && (en_edges % (2 * DH)) == DH));
      end
   end

   logic prev_step = 1'b0;
   int   rise_at = 0;
   int   cnt_at = 0;

   always @(negedge clk) begin
      pulse_t e;
      if (step_out === 1'b1 && !prev_step) begin
         rise_at = cyc;
         cnt_at  = int'(step_count);
      end
      if (step_out === 1'b0 && prev_step) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", rise_at, -1);
         end else begin
            e = sb.pop_front();
            check("pulse_rise", rise_at, e.rise);
            check("pulse_width", cyc - rise_at, e.width);
            check("pulse_count", cnt_at, e.cnt);
         end
      end
      prev_step = (step_out === 1'b1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_press(input int width);
      pulse_t e;
      exp_cnt++;
      e.rise  = cyc + 1 + LAT;
      e.width = width;
      e.cnt   = cnt_exp(exp_cnt);
      sb.push_back(e);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = 1'b1;
      div_en  = 1'b1;

      repeat (3) begin
         @(negedge clk);
         check("rst_step_out", int'(step_out), 0);
         check("rst_div_clk", int'(div_clk), 0);
         check("rst_div_rise", int'(div_rise), 0);
         check("rst_step_count", int'(step_count), 0);
      end
      rst_n = 1'b1;
      push_press(SH);
      wait_cyc(40);
      btn_raw = 1'b0;
      div_en  = 1'b0;
      wait_cyc(40);
      check("sb_after_reset", sb.size(), 0);

      btn_raw = 1'b1;
      push_press(SH);
      wait_cyc(100);
      btn_raw = 1'b0;
      wait_cyc(40);
      check("sb_after_clean", sb.size(), 0);
      check("count_after_clean", int'(step_count), cnt_exp(exp_cnt));

      for (int i = 0; i < 12; i++) begin
         btn_raw = ~i[0];
         wait_cyc(5);
      end
      btn_raw = 1'b0;
      wait_cyc(30);
      btn_raw = 1'b1;
      wait_cyc(10);
      btn_raw = 1'b0;
      wait_cyc(30);
      check("sb_after_bounce", sb.size(), 0);
      check("count_after_bounce", int'(step_count), cnt_exp(exp_cnt));

      div_en = 1'b1;
      wait_cyc(42);
      div_en = 1'b0;
      wait_cyc(5);
      div_en = 1'b1;
      wait_cyc(20);
      div_en = 1'b0;

      btn_raw = 1'b1;
      push_press(4);
      wait_cyc(LAT + 1 + 3);
      rst_n   = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      check("mid_reset_step_out", int'(step_out), 0);
      rst_n = 1'b1;
      push_press(SH);
      wait_cyc(40);
      btn_raw = 1'b0;
      wait_cyc(40);
      check("sb_after_mid_reset", sb.size(), 0);

      pulse_reset();
      wait_cyc(5);
      for (int i = 0; i < 256; i++) begin
         btn_raw = 1'b1;
         push_press(SH);
         wait_cyc(30);
         btn_raw = 1'b0;
         wait_cyc(30);
      end
      check("wrap_count", int'(step_count), 0);
      check("sb_after_wrap", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
